// File: rtl/fpga_uart_pkg.sv
// Shared types and constants for the UART receive monitor.
package fpga_uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } rx_state_t;

   // Counter value at which the start bit is checked: half a bit period
   // after the falling edge, so every later sample lands mid-bit.
   function automatic logic [15:0] half_bit(input int clks_per_bit);
      return 16'(clks_per_bit / 2 - 1);
   endfunction

endpackage

// File: rtl/fpga_uart_rx_monitor_if.sv
// Valid/ready pop port carrying received bytes out of the monitor FIFO.
interface fpga_uart_rx_monitor_if;
   import fpga_uart_pkg::*;

   logic [UART_DATA_BITS-1:0] rx_data;
   logic                      rx_valid;
   logic                      rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/fpga_sync_fifo.sv
// Single-clock FIFO with a registered show-ahead head and separate count register.
module fpga_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             head_valid,
   output logic [CNT_W-1:0] count,
   output logic             drop
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next, count_after_pop;
   logic [WIDTH-1:0] head_reg, head_next;
   logic             valid_reg;
   logic             full, do_pop, do_push;

   // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
   always_comb begin
      full            = (count_reg == CNT_W'(DEPTH));
      do_pop          = pop && (count_reg != '0);
      do_push         = push && (!full || do_pop);
      drop            = push && full && !do_pop;
      rd_ptr_next     = rd_ptr_reg + PTR_W'(do_pop);
      count_after_pop = count_reg - CNT_W'(do_pop);
      count_next      = count_after_pop + CNT_W'(do_push);
      // Bypass the array when the pushed byte becomes the new head.
      if (count_next == '0)
         head_next = '0;
      else if (do_push && (count_after_pop == '0))
         head_next = push_data;
      else
         head_next = mem[rd_ptr_next];
   end

   // Storage array, written without reset.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr_reg] <= push_data;
   end

   // Pointers, occupancy and the registered head/valid outputs.
   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         head_reg   <= '0;
         valid_reg  <= 1'b0;
      end else begin
         wr_ptr_reg <= wr_ptr_reg + PTR_W'(do_push);
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         head_reg   <= head_next;
         valid_reg  <= (count_next != '0);
      end
   end

   assign head       = head_reg;
   assign head_valid = valid_reg;
   assign count      = count_reg;
endmodule

// File: rtl/fpga_uart_rx_monitor.sv
// Oversampling 8N1 receiver that buffers decoded bytes and flags line errors.
module fpga_uart_rx_monitor
   import fpga_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 16,
   parameter int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                   CLK100MHZ,
   input  logic                   ck_rst,
   input  logic                   rxd,
   fpga_uart_rx_monitor_if.master rx,
   output logic                   frame_err,
   output logic                   overflow,
   output logic [CNT_W-1:0]       fifo_count
);
   localparam logic [15:0] HALF_BIT = half_bit(CLKS_PER_BIT);
   localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT - 1);

   logic [1:0]                sync_reg;
   logic                      rxd_s;
   rx_state_t                 state_reg, state_next;
   logic [15:0]               bit_cnt_reg;
   logic [2:0]                bit_idx_reg;
   logic [UART_DATA_BITS-1:0] shift_reg;
   logic                      frame_err_reg, overflow_reg;
   logic                      half_hit, bit_end;
   logic                      cnt_clr, idx_clr, shift_en, push, frame_bad;
   logic                      fifo_drop;

   assign rxd_s    = sync_reg[1];
   assign half_hit = (bit_cnt_reg == HALF_BIT);
   assign bit_end  = (bit_cnt_reg == FULL_BIT);

   // Two-flop synchroniser; resets to the idle (high) line level.
   always_ff @(posedge CLK100MHZ) begin
      if (ck_rst)
         sync_reg <= 2'b11;
      else
         sync_reg <= {sync_reg[0], rxd};
   end

   // FSM state register.
   always_ff @(posedge CLK100MHZ) begin
      if (ck_rst)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   // FSM next-state decode.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE:      if (!rxd_s) state_next = ST_START;
         ST_START:     if (half_hit) state_next = rxd_s ? ST_IDLE : ST_DATA;
         ST_DATA:      if (bit_end && (bit_idx_reg == 3'd7)) state_next = ST_STOP;
         ST_STOP:      if (bit_end) state_next = rxd_s ? ST_IDLE : ST_WAIT_IDLE;
         ST_WAIT_IDLE: if (rxd_s) state_next = ST_IDLE;
         default:      state_next = ST_IDLE;
      endcase
   end

   // FSM outputs: counter control, data sampling, push and frame-error strobes.
   always_comb begin
      cnt_clr   = 1'b0;
      idx_clr   = 1'b0;
      shift_en  = 1'b0;
      push      = 1'b0;
      frame_bad = 1'b0;
      unique case (state_reg)
         ST_IDLE, ST_WAIT_IDLE: cnt_clr = 1'b1;
         ST_START: if (half_hit) begin
            cnt_clr = 1'b1;
            idx_clr = 1'b1;
         end
         ST_DATA: if (bit_end) begin
            cnt_clr  = 1'b1;
            shift_en = 1'b1;
         end
         ST_STOP: if (bit_end) begin
            cnt_clr   = 1'b1;
            push      = rxd_s;
            frame_bad = !rxd_s;
         end
         default: cnt_clr = 1'b1;
      endcase
   end

   // Bit timing counter, bit index and LSB-first shift register.
   always_ff @(posedge CLK100MHZ) begin
      if (ck_rst) begin
         bit_cnt_reg <= '0;
         bit_idx_reg <= '0;
         shift_reg   <= '0;
      end else begin
         bit_cnt_reg <= cnt_clr ? 16'd0 : bit_cnt_reg + 16'd1;
         if (idx_clr)
            bit_idx_reg <= '0;
         else if (shift_en)
            bit_idx_reg <= bit_idx_reg + 3'd1;
         if (shift_en)
            shift_reg <= {rxd_s, shift_reg[UART_DATA_BITS-1:1]};
      end
   end

   // Error flags: one-cycle frame error pulse, sticky overflow.
   always_ff @(posedge CLK100MHZ) begin
      if (ck_rst) begin
         frame_err_reg <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         frame_err_reg <= frame_bad;
         if (fifo_drop)
            overflow_reg <= 1'b1;
      end
   end

   fpga_sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk        (CLK100MHZ),
      .srst       (ck_rst),
      .push       (push),
      .push_data  (shift_reg),
      .pop        (rx.rx_ready),
      .head       (rx.rx_data),
      .head_valid (rx.rx_valid),
      .count      (fifo_count),
      .drop       (fifo_drop)
   );

   assign frame_err = frame_err_reg;
   assign overflow  = overflow_reg;
endmodule

// File: tb/tb_fpga_uart_rx_monitor.sv
// Directed bench: bit-accurate 8N1 line driver, byte/flag monitor, hand-computed expectations.
module tb_fpga_uart_rx_monitor;
   import fpga_uart_pkg::*;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          ck_rst;
   logic          rxd;
   logic          frame_err;
   logic          overflow;
   logic [CW-1:0] fifo_count;

   fpga_uart_rx_monitor_if rxif ();

   fpga_uart_rx_monitor #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .CLK100MHZ  (clk),
      .ck_rst     (ck_rst),
      .rxd        (rxd),
      .rx         (rxif),
      .frame_err  (frame_err),
      .overflow   (overflow),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   int vec_cnt     = 0;
   int miscompares = 0;

   // Monitor log of popped bytes and flag activity, sampled just after the falling edge.
   logic [7:0] rx_log [0:255];
   int         rx_n        = 0;
   int         valid_cycles = 0;
   int         ferr_cycles  = 0;

   // Record every handshake, every rx_valid cycle and every frame_err cycle.
   always @(negedge clk) begin
      #1;
      if (rxif.rx_valid && rxif.rx_ready) begin
         rx_log[rx_n] = rxif.rx_data;
         rx_n++;
      end
      if (rxif.rx_valid) valid_cycles++;
      if (frame_err) ferr_cycles++;
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic drive_bit(input logic b);
      rxd = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop_bit);
   endtask

   int base, vbase, fbase;
   logic [7:0] b96;

   initial begin
      ck_rst = 1'b1;
      rxd    = 1'b1;
      rxif.rx_ready = 1'b1;
      repeat (4) @(negedge clk);
      ck_rst = 1'b0;
      @(negedge clk);
      check_value("rst_valid", 32'(rxif.rx_valid), 0);
      check_value("rst_data", 32'(rxif.rx_data), 0);
      check_value("rst_ferr", 32'(frame_err), 0);
      check_value("rst_ovf", 32'(overflow), 0);
      check_value("rst_count", 32'(fifo_count), 0);

      // Back-to-back frames, consumer always ready.
      base = rx_n; vbase = valid_cycles; fbase = ferr_cycles;
      send_frame(8'h55, 1'b1);
      send_frame(8'hA3, 1'b1);
      repeat (30) @(negedge clk);
      check_value("b2b_n", 32'(rx_n - base), 2);
      check_value("b2b_byte0", 32'(rx_log[base]), 32'h55);
      check_value("b2b_byte1", 32'(rx_log[base+1]), 32'hA3);
      check_value("b2b_valid_cycles", 32'(valid_cycles - vbase), 2);
      check_value("b2b_ferr", 32'(ferr_cycles - fbase), 0);
      check_value("b2b_ovf", 32'(overflow), 0);

      // Short low glitch on an idle line is rejected at the start-bit check.
      vbase = valid_cycles; fbase = ferr_cycles;
      rxd = 1'b0;
      repeat (5) @(negedge clk);
      rxd = 1'b1;
      repeat (30) @(negedge clk);
      check_value("glitch_state", 32'(dut.state_reg), 32'(ST_IDLE));
      check_value("glitch_valid", 32'(valid_cycles - vbase), 0);
      check_value("glitch_ferr", 32'(ferr_cycles - fbase), 0);

      // Stop bit low, line held low, then a clean frame.
      base = rx_n; fbase = ferr_cycles;
      send_frame(8'h3C, 1'b0);
      rxd = 1'b0;
      repeat (40) @(negedge clk);
      check_value("ferr_pulses", 32'(ferr_cycles - fbase), 1);
      check_value("ferr_count", 32'(fifo_count), 0);
      check_value("ferr_wait_state", 32'(dut.state_reg), 32'(ST_WAIT_IDLE));
      rxd = 1'b1;
      repeat (16) @(negedge clk);
      send_frame(8'h7E, 1'b1);
      repeat (20) @(negedge clk);
      check_value("ferr_recover_n", 32'(rx_n - base), 1);
      check_value("ferr_recover_byte", 32'(rx_log[base]), 32'h7E);

      // Fill to four, then pop exactly on the edge that pushes the fifth byte.
      rxif.rx_ready = 1'b0;
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
      check_value("coinc_fill_count", 32'(fifo_count), 4);
      base = rx_n;
      fork
         send_frame(8'h05, 1'b1);
         begin
            // Stop-bit sample edge is the 155th rising edge after the start bit is driven.
            repeat (154) @(negedge clk);
            rxif.rx_ready = 1'b1;
            @(negedge clk);
            rxif.rx_ready = 1'b0;
         end
      join
      repeat (4) @(negedge clk);
      check_value("coinc_count", 32'(fifo_count), 4);
      check_value("coinc_ovf", 32'(overflow), 0);
      check_value("coinc_head", 32'(rxif.rx_data), 32'h02);
      rxif.rx_ready = 1'b1;
      repeat (8) @(negedge clk);
      check_value("coinc_n", 32'(rx_n - base), 5);
      for (int i = 0; i < 5; i++)
         check_value($sformatf("coinc_byte%0d", i), 32'(rx_log[base+i]), 32'(i + 1));
      check_value("coinc_drained", 32'(fifo_count), 0);

      // Overflow: five bytes into a four-deep FIFO with no consumer.
      rxif.rx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      repeat (4) @(negedge clk);
      check_value("ovf_count", 32'(fifo_count), 4);
      check_value("ovf_flag", 32'(overflow), 1);
      check_value("ovf_head", 32'(rxif.rx_data), 32'h01);
      base = rx_n;
      rxif.rx_ready = 1'b1;
      repeat (3) @(negedge clk);
      rxif.rx_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_value("ovf_pop_n", 32'(rx_n - base), 3);
      for (int i = 0; i < 3; i++)
         check_value($sformatf("ovf_byte%0d", i), 32'(rx_log[base+i]), 32'(i + 1));
      check_value("ovf_left_count", 32'(fifo_count), 1);
      check_value("ovf_left_head", 32'(rxif.rx_data), 32'h04);
      check_value("ovf_sticky", 32'(overflow), 1);

      // Reset in the middle of the data bits of 0x96.
      b96 = 8'h96;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(b96[i]);
      check_value("mid_state", 32'(dut.state_reg), 32'(ST_DATA));
      ck_rst = 1'b1;
      rxd    = 1'b1;
      @(negedge clk);
      check_value("mrst_valid", 32'(rxif.rx_valid), 0);
      check_value("mrst_data", 32'(rxif.rx_data), 0);
      check_value("mrst_ferr", 32'(frame_err), 0);
      check_value("mrst_ovf", 32'(overflow), 0);
      check_value("mrst_count", 32'(fifo_count), 0);
      check_value("mrst_state", 32'(dut.state_reg), 32'(ST_IDLE));
      @(negedge clk);
      ck_rst = 1'b0;
      rxif.rx_ready = 1'b1;
      repeat (20) @(negedge clk);
      base = rx_n; fbase = ferr_cycles;
      send_frame(8'h69, 1'b1);
      repeat (20) @(negedge clk);
      check_value("post_rst_n", 32'(rx_n - base), 1);
      check_value("post_rst_byte", 32'(rx_log[base]), 32'h69);
      check_value("post_rst_ferr", 32'(ferr_cycles - fbase), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
      $finish;
   end
endmodule
